// File: rtl/rpi_irq_scheduler.sv
// rpi_irq_scheduler: funnels up to NUM_SRC audio-side interrupt requests onto one
// Pi-facing interrupt line, one at a time, with round-robin grants.
// Each interrupt stays asserted until the Pi acks it. A hold-off gap follows every ack.
//
// Ports:
//   clk_in       50 MHz system clock
//   reset        synchronous, active-high reset
//   src_req      per-source request levels; a rising edge sets the pending flag
//   ack_in       asynchronous Pi acknowledge; synchronized with two flops
//   irq_out      interrupt line to the Pi, active high
//   irq_id       index of the source being serviced; valid while irq_out=1
//   pending      sticky pending flags, for debug
//   busy         high whenever the block is not idle
//   timeout_err  one-cycle pulse on ack timeout
//
// Optional feature: define IRQ_TIMEOUT_EN to enable the ack timeout.
// Without it, ASSERT waits forever and timeout_err is constant 0.
module rpi_irq_scheduler #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned HOLDOFF_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES = 131072
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic               ack_in,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               timeout_err
);

  if (NUM_SRC < 2 || NUM_SRC > 8 || NUM_SRC > (1 << ID_W)) begin : g_bad_num_src
    $error("rpi_irq_scheduler: NUM_SRC must be 2..8 and fit in ID_W bits");
  end
  if (HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("rpi_irq_scheduler: HOLDOFF_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  localparam int unsigned HoW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

  state_e             state_q, state_d;
  logic               ack_m_q, ack_s_q, ack_s_prev_q;
  logic               ack_rise;
  logic [NUM_SRC-1:0] src_q, rise, clr;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [HoW-1:0]     hold_q, hold_d;
  logic               irq_q, irq_d;
  logic               busy_q, busy_d;
  logic               to_err_q, to_err_d;
  logic               to_fire;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      sum;
  logic [ID_W-1:0]    cand;

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign ack_rise  = ack_s_q & ~ack_s_prev_q;
  assign rise      = src_req & ~src_q;
  // A rise in the same cycle as the clear wins, so the source is serviced again.
  assign pending_d = (pending_q & ~clr) | rise;

  // Round-robin search starting one past the last grant, wrapping at NUM_SRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      sum = {1'b0, last_q} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(NUM_SRC)) sum = sum - (ID_W + 1)'(NUM_SRC);
      cand = ID_W'(sum);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= StIdle;
      ack_m_q      <= 1'b0;
      ack_s_q      <= 1'b0;
      ack_s_prev_q <= 1'b0;
      // Track levels during reset so requests held across it do not count as rises.
      src_q        <= src_req;
      pending_q    <= '0;
      last_q       <= ID_W'(NUM_SRC - 1);
      id_q         <= '0;
      hold_q       <= '0;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      to_err_q     <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ack_m_q      <= ack_in;
      ack_s_q      <= ack_m_q;
      ack_s_prev_q <= ack_s_q;
      src_q        <= src_req;
      pending_q    <= pending_d;
      last_q       <= last_d;
      id_q         <= id_d;
      hold_q       <= hold_d;
      irq_q        <= irq_d;
      busy_q       <= busy_d;
      to_err_q     <= to_err_d;
`ifdef IRQ_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    hold_d  = hold_q;
    clr     = '0;
    to_fire = 1'b0;
`ifdef IRQ_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          id_d    = win_idx;
          last_d  = win_idx;
          state_d = StAssert;
`ifdef IRQ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      StAssert: begin
        if (ack_rise) begin
          clr[id_q] = 1'b1;
          hold_d    = HoW'(HOLDOFF_CYCLES - 1);
          state_d   = StHoldoff;
        end
`ifdef IRQ_TIMEOUT_EN
        // Pending stays set on timeout; last has already moved past this source.
        else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          to_fire = 1'b1;
          hold_d  = HoW'(HOLDOFF_CYCLES - 1);
          state_d = StHoldoff;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      StHoldoff: begin
        // A Pi still holding ack high keeps us here after the count expires.
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (!ack_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: computed from the next state so every output is a flop.
  always_comb begin
    irq_d    = (state_d == StAssert);
    busy_d   = (state_d != StIdle);
    to_err_d = to_fire;
  end

  assign irq_out     = irq_q;
  assign irq_id      = id_q;
  assign pending     = pending_q;
  assign busy        = busy_q;
  assign timeout_err = to_err_q;

endmodule

// File: doc/rpi_irq_scheduler.md
# rpi_irq_scheduler

Collects interrupt requests from up to NUM_SRC audio-side sources (I2S RX/TX FIFO thresholds, codec status) and presents them one at a time to the Raspberry Pi on a single interrupt line. Grants are round-robin. Each interrupt is held until the Pi acknowledges it on a GPIO ack line, followed by a hold-off gap. Sits between the audio datapath status flags and the Pi-facing interrupt pin, in the 50 MHz `clk_in` domain.

## Interface
Parameters:
- `NUM_SRC`, 4: number of request sources, 2..8.
- `ID_W`, 2: width of `irq_id`; requires NUM_SRC ≤ 2^ID_W.
- `HOLDOFF_CYCLES`, 64: minimum `irq_out`-low gap after each ack, ≥1.
- `TIMEOUT_CYCLES`, 131072: ack timeout; used only with IRQ_TIMEOUT_EN.

Ports:
- `clk_in`  in  1  50 MHz system clock.
- `reset`  in  1  synchronous, active-high reset.
- `src_req`  in  NUM_SRC  per-source request levels, synchronous to `clk_in`.
- `ack_in`  in  1  Pi acknowledge, asynchronous.
- `irq_out`  out  1  interrupt line to the Pi, active high.
- `irq_id`  out  ID_W  index of the source being serviced; valid while `irq_out`=1.
- `pending`  out  NUM_SRC  sticky pending flags, readable for debug.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse on ack timeout. Tied 0 without IRQ_TIMEOUT_EN.

## Operation
- `ack_in` passes through a 2-FF synchronizer to give `ack_s`. Only the rising edge of `ack_s` (`ack_rise`) is used as an acknowledge.
- Each source has a registered copy of its previous request level; a rising edge on `src_req[i]` is `rise[i]`.
- Pending update each cycle: `pending[i] <= (pending[i] & ~clr[i]) | rise[i]`.
  - `clr[i]` is asserted when source i is acknowledged.
  - Simultaneous rise and clear: rise wins, so the bit stays set.
- Round-robin pointer `last` resets to NUM_SRC-1, so source 0 has first priority.
  - The search runs from `last`+1 upward, modulo NUM_SRC.
  - The winner is the first set pending bit in that order.
- States:
  - **IDLE**: `irq_out`=0. If any pending bit is set, latch winner into `irq_id`, set `last`=winner, go to ASSERT.
  - **ASSERT**: `irq_out`=1, `irq_id` stable. On `ack_rise`: clear `pending[irq_id]`, drop `irq_out`, load hold-off counter with HOLDOFF_CYCLES-1, go to HOLDOFF.
  - **HOLDOFF**: `irq_out`=0. Count down to 0; return to IDLE only once the counter is 0 and `ack_s`=0.
- A Pi holding ack high stalls the block in HOLDOFF; no new interrupt is issued.
- Requests arriving during ASSERT or HOLDOFF are only recorded in `pending`; they never preempt the current interrupt.
- Reset mid-operation: state→IDLE, `irq_out`=0, all pending cleared, `last`=NUM_SRC-1, synchronizer flops cleared. Reset overrides every other event in the same cycle.

## Timing
- Reset values: `irq_out`=0, `irq_id`=0, `pending`=0, `busy`=0, `timeout_err`=0.
- All outputs are registered.
- Request-to-interrupt latency from an idle block:
  - `src_req` rises in cycle N → `pending` set in N+1 → IDLE sees it → `irq_out`=1 in N+2.
- Ack latency:
  - `ack_in` rises before edge M → `ack_s` high after edge M+1 → `irq_out` falls and pending clears after edge M+2.
  - Total: 2–3 cycles depending on async arrival.
- `irq_out` low time between interrupts: at least HOLDOFF_CYCLES+1 cycles, where the +1 is the IDLE cycle.
- `busy`=1 from the ASSERT entry cycle through the last HOLDOFF cycle.

## Configuration
- `IRQ_TIMEOUT_EN` defined:
  - A counter runs in ASSERT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without `ack_rise`: `irq_out` drops, `timeout_err` pulses for one cycle, state goes to HOLDOFF.
  - The pending bit is **not** cleared, so the source is retried.
  - `last` still advances, so other sources get the next grant.
- `IRQ_TIMEOUT_EN` undefined: no timeout counter; ASSERT waits indefinitely; `timeout_err` is constant 0.

## Test plan
- **Reset**: reset for 3 cycles with `src_req`=4'b1111 → `irq_out`=0, `pending`=0, `busy`=0 throughout. After release, rises are ignored until levels are seen low then high again.
- **Single source**: pulse `src_req[2]` for 1 cycle → `irq_out`=1 and `irq_id`=2 two cycles later. Ack → `irq_out`=0 within 3 cycles, `pending[2]`=0, `irq_out` stays low ≥65 cycles with HOLDOFF_CYCLES=64.
- **Round robin**: raise all four requests in the same cycle and ack each grant → `irq_id` sequence 0,1,2,3. Re-raise 0 and 3 → next grants are 0 then 3.
- **Collision**: `src_req[1]` rises in the same cycle `pending[1]` is cleared by ack → `pending[1]` remains 1 and source 1 is re-serviced after hold-off.
- **Stuck ack**: hold `ack_in`=1 for 200 cycles after an ack → block remains in HOLDOFF with `irq_out`=0. IDLE is entered only after `ack_s` falls.
- **Timeout (IRQ_TIMEOUT_EN, TIMEOUT_CYCLES=100)**: never ack → `timeout_err` pulses once, `irq_out` falls, pending bit still set, `irq_out` re-asserts after hold-off. Mid-ASSERT reset → `irq_out`=0 on the next edge.
